// File: rtl/mul8_seq.sv
// mul8_seq: multi-cycle unsigned shift-add multiplier driving a shared external adder
module mul8_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] m, acc_hi, acc_lo;
  logic [CNT_W-1:0] cnt;
  logic last;
  logic [2*WIDTH-1:0] shifted;
  always_comb begin
    last = cnt == CNT_W'(WIDTH - 1);
    state_nxt = state == IDLE ? (start ? CALC : IDLE) :
                state == CALC ? (last ? DONE : CALC) : IDLE;
    busy = state == CALC;
    done = state == DONE;
    add_a = busy ? acc_hi : '0;
    add_b = busy && acc_lo[0] ? m : '0;
    // carry-out becomes the new MSB so full-range operands are not truncated
    shifted = {add_cout, add_sum, acc_lo[WIDTH-1:1]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        m <= a;
        acc_hi <= '0;
        acc_lo <= b;
        cnt <= '0;
      end else if (state == CALC) begin
        {acc_hi, acc_lo} <= shifted;
        cnt <= cnt + 1'b1;
        if (last) product <= shifted;
      end
    end
  end
endmodule

// File: tb/tb_mul8_seq.sv
// tb_mul8_seq: directed checks of the sequential multiplier with a combinational adder model
module tb_mul8_seq;
  logic clk, rst_n, start, busy, done, add_cout;
  logic [7:0] a, b, add_a, add_b, add_sum;
  logic [15:0] product;
  int checks = 0;
  int failures = 0;
  logic saw_done;

  mul8_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_mul(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp, input string tag);
    @(negedge clk);
    a = x; b = y; start = 1;
    @(negedge clk);
    start = 0; a = ~x; b = ~y;
    check({tag, "_busy0"}, 16'(busy), 16'd1);
    check({tag, "_adda0"}, 16'(add_a), 16'd0);
    check({tag, "_addb0"}, 16'(add_b), y[0] ? 16'(x) : 16'd0);
    repeat (7) @(negedge clk);
    check({tag, "_busy7"}, 16'(busy), 16'd1);
    check({tag, "_nodone7"}, 16'(done), 16'd0);
    @(negedge clk);
    check({tag, "_done"}, 16'(done), 16'd1);
    check({tag, "_busyoff"}, 16'(busy), 16'd0);
    check({tag, "_prod"}, product, exp);
    @(negedge clk);
    check({tag, "_pulse"}, 16'(done), 16'd0);
    check({tag, "_hold"}, product, exp);
    check({tag, "_idle_adda"}, 16'(add_a), 16'd0);
  endtask

  initial begin
    rst_n = 0; start = 0; a = 0; b = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_prod", product, 16'h0000);
    rst_n = 1;
    repeat (2) @(negedge clk);
    check("idle_busy", 16'(busy), 16'd0);
    check("idle_done", 16'(done), 16'd0);
    check("idle_prod", product, 16'h0000);
    check("idle_adda", 16'(add_a), 16'd0);
    check("idle_addb", 16'(add_b), 16'd0);

    run_mul(8'd13, 8'd11, 16'h008F, "m13x11");
    run_mul(8'hFF, 8'hFF, 16'hFE01, "mffxff");
    run_mul(8'h0F, 8'h0F, 16'h00E1, "m0fx0f");
    run_mul(8'h00, 8'hAB, 16'h0000, "m00xab");
    run_mul(8'h01, 8'hAB, 16'h00AB, "m01xab");

    // start held high: second accept lands on the first IDLE cycle with the new operands
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 9) begin
        check("hold_done1", 16'(done), 16'd1);
        check("hold_prod1", product, 16'h000F);
      end
      if (c == 10) begin
        check("hold_idle_busy", 16'(busy), 16'd0);
        check("hold_idle_done", 16'(done), 16'd0);
      end
      if (c == 11) begin
        check("hold_reaccept", 16'(busy), 16'd1);
        check("hold_prod_kept", product, 16'h000F);
      end
      if (c == 18) check("hold_nodone_early", 16'(done), 16'd0);
      if (c == 19) begin
        check("hold_done2", 16'(done), 16'd1);
        check("hold_prod2", product, 16'h0031);
      end
      start = c < 12;
      if (c == 0) begin a = 8'd3; b = 8'd5; end
      if (c == 2) begin a = 8'd7; b = 8'd7; end
    end
    start = 0;
    @(negedge clk);

    // reset mid-operation
    a = 8'hFF; b = 8'h02; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    check("abort_busy_pre", 16'(busy), 16'd1);
    rst_n = 0;
    #1;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_done", 16'(done), 16'd0);
    check("abort_prod", product, 16'h0000);
    check("abort_adda", 16'(add_a), 16'd0);
    @(negedge clk);
    rst_n = 1;
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("abort_no_done", 16'(saw_done), 16'd0);
    check("abort_prod_after", product, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
